// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI serial-SRAM bridge.
//   - SPI command bytes for the 23LC512-class memory
//   - 3-bit FSM state encoding
//   - frame length and the helper that assembles an outgoing frame
package spi_mem_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam int unsigned FRAME_BITS = 32;

  // SCK edges per frame are numbered 0..63; 63 is the final falling edge.
  localparam logic [5:0] LAST_EDGE = 6'd63;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_CS_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // {cmd, address, data}; a read sends a dummy 8'h00 data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input op_e op,
                                                        input logic [15:0] addr,
                                                        input logic [7:0] wdata);
    if (op == OP_WRITE) begin
      build_frame = {SPI_CMD_WRITE, addr, wdata};
    end else begin
      build_frame = {SPI_CMD_READ, addr, 8'h00};
    end
  endfunction

endpackage

// File: rtl/spi_mem_bridge_if.sv
// CPU-side byte bus of the SPI memory bridge.
//   bus_address_in / bus_wdata : request address and write data
//   bus_read / bus_write       : request levels, held until bus_done
//   bus_rdata / bus_done       : read data and one-cycle completion pulse
// master = cpu side, slave = bridge side.
interface spi_mem_bridge_if;
  logic [15:0] bus_address_in;
  logic [7:0]  bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_rdata;
  logic        bus_done;

  modport master (
    output bus_address_in, bus_wdata, bus_read, bus_write,
    input  bus_rdata, bus_done
  );

  modport slave (
    input  bus_address_in, bus_wdata, bus_read, bus_write,
    output bus_rdata, bus_done
  );
endinterface

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for the SPI clock.
//   clk, rst_n : system clock, synchronous active-low reset
//   en_i       : count while high
//   clr_i      : synchronous clear of the counter (dominates en_i)
//   tick_o     : one-cycle pulse every CLK_DIV enabled cycles
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Tick on the last count of a phase; wrapping to 0 there starts the next phase.
  assign tick_o = en_i && !clr_i && (cnt_q == LAST_CNT);

  // Next count: clear, wrap on tick, or increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// Bridge from single-byte CPU bus requests to 32-bit SPI mode-0 frames on a
// 64 KiB serial SRAM. One transaction in flight.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : CPU byte bus (slave side)
//   spi_cs_n   : chip select, active low
//   spi_sck    : SPI clock, idles low, half-period CLK_DIV cycles
//   spi_mosi   : frame bits MSB first, 0 whenever deselected
//   spi_miso   : memory data, sampled on SCK rising edges
module spi_mem_bridge #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_mem_bridge_if.slave bus,
  output logic            spi_cs_n,
  output logic            spi_sck,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  import spi_mem_pkg::*;

  logic [2:0]  state_q, state_d;
  op_e         op_q, op_d;
  logic [30:0] tx_q, tx_d;       // frame bits not yet on mosi, next bit at [30]
  logic [7:0]  rx_q, rx_d;       // last 8 miso samples
  logic [5:0]  edge_q, edge_d;   // SCK edges issued so far in this frame
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [31:0] frame_s;
  logic        div_en_s;
  logic        tick_s;

  // Divider only runs while the frame is active; IDLE/DONE hold it cleared.
  assign div_en_s = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                    (state_q == ST_CS_HOLD);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (div_en_s),
    .clr_i  (!div_en_s),
    .tick_o (tick_s)
  );

  assign op_d    = bus.bus_write ? OP_WRITE : OP_READ;
  assign frame_s = build_frame(op_d, bus.bus_address_in, bus.bus_wdata);

  // Transaction FSM, shift registers and SPI pin next-state.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    edge_d  = edge_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.bus_read || bus.bus_write) begin
          tx_d    = frame_s[30:0];
          mosi_d  = frame_s[31];
          cs_n_d  = 1'b0;
          edge_d  = 6'd0;
          state_d = ST_CS_SETUP;
        end else begin
          cs_n_d  = 1'b1;
          sck_d   = 1'b0;
          mosi_d  = 1'b0;
        end
      end
      ST_CS_SETUP: begin
        // End of setup is also the first rising edge of the frame.
        if (tick_s) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], spi_miso};
          edge_d  = 6'd1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_CS_SETUP;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          if (!sck_q) begin
            sck_d  = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso};
            edge_d = edge_q + 6'd1;
          end else begin
            sck_d = 1'b0;
            if (edge_q == LAST_EDGE) begin
              // Counter stays at 63 until the next acceptance clears it.
              mosi_d  = 1'b0;
              state_d = ST_CS_HOLD;
            end else begin
              mosi_d = tx_q[30];
              tx_d   = {tx_q[29:0], 1'b0};
              edge_d = edge_q + 6'd1;
            end
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_CS_HOLD: begin
        if (tick_s) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          rdata_d = (op_q == OP_READ) ? rx_q : rdata_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CS_HOLD;
        end
      end
      ST_DONE: begin
        // Requests are not sampled here so cs_n stays high at least two cycles.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // Op type is captured only at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= OP_READ;
    end else if (state_q == ST_IDLE) begin
      op_q <= op_d;
    end else begin
      op_q <= op_q;
    end
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 31'd0;
      rx_q    <= 8'h00;
      edge_q  <= 6'd0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      edge_q  <= edge_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign spi_cs_n      = cs_n_q;
  assign spi_sck       = sck_q;
  assign spi_mosi      = mosi_q;
  assign bus.bus_done  = done_q;
  assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: one instance with CLK_DIV=1 and one with CLK_DIV=3,
// a serial-SRAM model on the pins, a table of directed vectors, random traffic
// and hand-written reset sequences.
module tb_spi_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_rd, req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        miso;
  logic        cs0, sck0, mosi0, cs1, sck1, mosi1;

  spi_mem_bridge_if bif0();
  spi_mem_bridge_if bif1();

  assign bif0.bus_read       = req_rd & ~sel;
  assign bif0.bus_write      = req_wr & ~sel;
  assign bif0.bus_address_in = req_addr;
  assign bif0.bus_wdata      = req_wdata;
  assign bif1.bus_read       = req_rd & sel;
  assign bif1.bus_write      = req_wr & sel;
  assign bif1.bus_address_in = req_addr;
  assign bif1.bus_wdata      = req_wdata;

  spi_mem_bridge #(.CLK_DIV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bif0),
    .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso)
  );

  spi_mem_bridge #(.CLK_DIV(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bif1),
    .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso)
  );

  wire       o_cs    = sel ? cs1 : cs0;
  wire       o_sck   = sel ? sck1 : sck0;
  wire       o_mosi  = sel ? mosi1 : mosi0;
  wire       o_done  = sel ? bif1.bus_done : bif0.bus_done;
  wire [7:0] o_rdata = sel ? bif1.bus_rdata : bif0.bus_rdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents model and per-instance last-read-data model.
  logic [7:0] mem [int];
  logic [7:0] rd_model [2];

  function automatic logic [7:0] mem_get(input logic [15:0] a);
    if (!mem.exists(int'(a))) mem[int'(a)] = 8'($urandom);
    return mem[int'(a)];
  endfunction

  // Serial SRAM pin model: plays resp MSB first on miso, captures mosi on SCK rises.
  logic [31:0] resp;
  logic [31:0] cap;
  int          nrise;
  logic        prev_sck, prev_cs;
  int          cyc = 0;
  int          t_csrise;
  bit          have_rise;
  int          idle_sck_err = 0;
  int          idle_mosi_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    miso = 1'b0; nrise = 0; prev_sck = 1'b0; prev_cs = 1'b1; have_rise = 0;
    cap = 32'd0; t_csrise = 0; resp = 32'd0;
    forever begin
      @(negedge clk);
      if (o_cs) begin
        if (!prev_cs) begin
          t_csrise  = cyc;
          have_rise = 1;
        end
        if (o_sck !== 1'b0) idle_sck_err++;
        if (o_mosi !== 1'b0) idle_mosi_err++;
        nrise = 0;
        miso  = 1'b0;
      end else begin
        if (prev_cs) begin
          cap = 32'd0;
          if (have_rise) chk("cs_high_gap", 32'(cyc - t_csrise >= 2), 32'd1);
        end
        if (o_sck && !prev_sck) begin
          cap   = {cap[30:0], o_mosi};
          nrise = nrise + 1;
        end
        miso = (nrise < 32) ? resp[31 - nrise] : 1'b0;
      end
      prev_sck = o_sck;
      prev_cs  = o_cs;
    end
  end

  // One bus transaction with full timing checks. Called at a negedge.
  task automatic run_txn(input bit wr, input bit both, input bit s,
                         input logic [15:0] addr, input logic [7:0] wd,
                         input bit chg, input bit keep,
                         input logic [31:0] exp_frame, input logic [7:0] exp_rd);
    int D, n, w, sck_err, cs_err, done_err, mosi_err;
    bit eff_wr, got, exp_sck;
    logic [31:0] tmp;
    D = s ? 3 : 1;
    eff_wr = wr | both;
    if (s != sel) have_rise = 0;
    sel = s;
    tmp = $urandom;
    resp = {tmp[31:8], eff_wr ? tmp[7:0] : mem_get(addr)};
    req_rd = !wr || both;
    req_wr = wr || both;
    req_addr = addr;
    req_wdata = wd;
    w = 0;
    while (w < 4) begin
      @(negedge clk);
      w++;
      if (!o_cs) break;
    end
    chk("accept_cs_low", o_cs, 1'b0);
    if (o_cs) begin
      req_rd = 1'b0; req_wr = 1'b0;
      return;
    end
    chk("accept_delay", w, 1);
    n = 0; got = 0; sck_err = 0; cs_err = 0; done_err = 0; mosi_err = 0;
    while (n <= 65 * D + 2 && !got) begin
      if (n < 65 * D) begin
        exp_sck = ((n / D) % 2) == 1;
        if (o_sck !== exp_sck) sck_err++;
        if (o_cs !== 1'b0) cs_err++;
        if (o_done !== 1'b0) done_err++;
        if (n >= 64 * D && o_mosi !== 1'b0) mosi_err++;
      end
      if (chg && n == 20 * D) begin
        req_addr  = 16'hFFFF;
        req_wdata = ~wd;
      end
      if (o_done === 1'b1) begin
        got = 1;
        chk("done_latency", n, 65 * D);
        chk("done_cs_high", o_cs, 1'b1);
        chk("done_rdata", o_rdata, exp_rd);
        chk("mosi_frame", cap, exp_frame);
        if (!keep) begin
          req_rd = 1'b0; req_wr = 1'b0;
        end
      end else begin
        @(negedge clk);
        n++;
      end
    end
    chk("done_seen", got, 1'b1);
    chk("sck_wave_err", sck_err, 0);
    chk("cs_low_err", cs_err, 0);
    chk("early_done_err", done_err, 0);
    chk("mosi_tail_err", mosi_err, 0);
    if (!got) begin
      req_rd = 1'b0; req_wr = 1'b0;
    end
    if (eff_wr) mem[int'(addr)] = wd;
    else rd_model[s] = mem_get(addr);
    @(negedge clk);
    chk("done_one_cycle", o_done, 1'b0);
    chk("no_accept_in_done", o_cs, 1'b1);
    chk("rdata_held", o_rdata, exp_rd);
  endtask

  typedef struct {
    bit          wr;
    bit          both;
    bit          s;
    logic [15:0] addr;
    logic [7:0]  wd;
    bit          chg;
    bit          keep;
    bit          use_pre;
    logic [7:0]  pre;
    logic [31:0] exp_frame;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int cnt, w;
    bit rw, rb, rs;
    logic [15:0] ra;
    logic [7:0] rwd, rexp;
    logic [31:0] tmp;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 32'h03123400, 8'hA5};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0042, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 32'h03004200, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'hBEEF, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 32'h02BEEF5A, 8'h3C};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'hBEEF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h03BEEF00, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b1, 1'b1, 8'h81, 32'h03010000, 8'h81};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0100, 8'hE7, 1'b0, 1'b0, 1'b0, 8'h00, 32'h020100E7, 8'h81};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h00FF, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0200FFC3, 8'h81};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0300FF00, 8'hC3};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 16'h2222, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 32'h02222211, 8'h5A};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 16'h2222, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 32'h03222200, 8'h11};

    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;

    // Reset held 3 cycles with a read request pending.
    rst_n = 1'b0; sel = 1'b0; req_rd = 1'b1; req_wr = 1'b0;
    req_addr = 16'h0010; req_wdata = 8'h00;
    mem[16'h0010] = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("rst_cs_n", {cs1, o_cs}, 2'b11);
      chk("rst_sck", {sck1, o_sck}, 2'b00);
      chk("rst_mosi", {mosi1, o_mosi}, 2'b00);
      chk("rst_done", {bif1.bus_done, o_done}, 2'b00);
      chk("rst_rdata", o_rdata, 8'h00);
    end
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 32'h03001000, 8'h77);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].use_pre) mem[int'(vecs[i].addr)] = vecs[i].pre;
      run_txn(vecs[i].wr, vecs[i].both, vecs[i].s, vecs[i].addr, vecs[i].wd,
              vecs[i].chg, vecs[i].keep, vecs[i].exp_frame, vecs[i].exp_rd);
    end

    // Random traffic against the memory model.
    for (int i = 0; i < 30; i++) begin
      rs  = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      rb  = ($urandom_range(0, 7) == 0);
      tmp = $urandom;
      ra  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : tmp[15:0];
      rwd = 8'($urandom);
      if (rw || rb) rexp = rd_model[rs];
      else rexp = mem_get(ra);
      run_txn(rw, rb, rs, ra, rwd, 1'b0, 1'b0,
              (rw || rb) ? {8'h02, ra, rwd} : {8'h03, ra, 8'h00}, rexp);
    end

    // Reset in the middle of the frame, at the rising edge of bit 17.
    have_rise = 0;
    sel = 1'b0;
    mem[16'h0020] = 8'h9C;
    tmp = $urandom;
    resp = {tmp[31:8], 8'h9C};
    req_addr = 16'h0020; req_wr = 1'b0; req_rd = 1'b1;
    w = 0;
    while (w < 4) begin
      @(negedge clk);
      w++;
      if (!o_cs) break;
    end
    chk("mid_accept", o_cs, 1'b0);
    repeat (35) @(negedge clk);
    chk("mid_sck_high", o_sck, 1'b1);
    rst_n = 1'b0; req_rd = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs_n", o_cs, 1'b1);
    chk("mid_rst_sck", o_sck, 1'b0);
    chk("mid_rst_mosi", o_mosi, 1'b0);
    chk("mid_rst_done", o_done, 1'b0);
    chk("mid_rst_rdata", o_rdata, 8'h00);
    rst_n = 1'b1;
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_done !== 1'b0) cnt++;
    end
    chk("no_done_after_abort", cnt, 0);
    run_txn(1'b0, 1'b0, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b0, 32'h03002000, 8'h9C);

    chk("idle_sck_err", idle_sck_err, 0);
    chk("idle_mosi_err", idle_mosi_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
